prog_loader: RTL and testbench

Host-side counterpart of the CPU's instruction fetch path and start/done handshake. It accepts a stream of 9-bit instruction words over a valid/ready interface and writes them sequentially into instruction memory from address 0. It then pulses the CPU's start input and waits for done, counting run cycles. It sits beside top_level, driving instr_memory's write port and the CPU start pin, and observing the CPU done pin.

---
 rtl/prog_loader_pkg.sv | 18 +
 rtl/sat_counter.sv | 26 ++
 rtl/prog_loader.sv | 138 +++++++++++++
 tb/tb_prog_loader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types for the program loader: FSM states and sticky error codes.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    ERROR = 3'd4
  } loader_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_OVERFLOW = 2'd1,
    ERR_TIMEOUT  = 2'd2
  } loader_err_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a registered at-max flag.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         at_max
);

  localparam logic [W-1:0] MAX_M1 = {{(W-1){1'b1}}, 1'b0};

  // at_max tracks count == all-ones so the increment gate needs no wide compare
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count  <= '0;
      at_max <= 1'b0;
    end else if (inc && !at_max) begin
      count  <= count + 1'b1;
      at_max <= (count == MAX_M1);
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Streams a program into instruction memory, pulses CPU start, then times the run until done.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned IM_SIZE      = 1024,
  parameter int unsigned AW           = 10,
  parameter int unsigned IW           = 9,
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned CYC_W        = 16,
  parameter int unsigned TIMEOUT      = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_req,
  input  logic             in_valid,
  input  logic [IW-1:0]    in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             im_wr_en,
  output logic [AW-1:0]    im_wr_addr,
  output logic [IW-1:0]    im_wr_data,
  output logic             start,
  input  logic             done,
  output logic             busy,
  output logic             run_done,
  output logic [1:0]       err_code,
  output logic [CYC_W-1:0] run_cycles,
  output logic [AW:0]      words_loaded
);

  localparam int unsigned SCW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  loader_state_t  state;
  loader_err_t    err_q;
  logic [AW-1:0]  addr;
  logic [SCW-1:0] st_cnt;
  logic           cnt_clr;
  logic           cnt_inc;
  logic           run_at_max;
  logic           timeout_hit;

  assign err_code = err_q;

  always_comb begin
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    timeout_hit = 1'b0;
    cnt_clr     = (state == IDLE) && load_req;
    cnt_inc     = (state == RUN) && !done;
    timeout_hit = (run_cycles == CYC_W'(TIMEOUT - 1)) || run_at_max;
  end

  sat_counter #(.W(CYC_W)) u_run_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .count  (run_cycles),
    .at_max (run_at_max)
  );

  // Outputs are updated alongside each transition so they match the state they belong to
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      err_q        <= ERR_NONE;
      addr         <= '0;
      st_cnt       <= '0;
      in_ready     <= 1'b0;
      im_wr_en     <= 1'b0;
      im_wr_addr   <= '0;
      im_wr_data   <= '0;
      start        <= 1'b0;
      busy         <= 1'b0;
      run_done     <= 1'b0;
      words_loaded <= '0;
    end else begin
      im_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (load_req) begin
            run_done     <= 1'b0;
            err_q        <= ERR_NONE;
            words_loaded <= '0;
            addr         <= '0;
            in_ready     <= 1'b1;
            busy         <= 1'b1;
            state        <= LOAD;
          end
        end
        LOAD: begin
          if (in_valid && in_ready) begin
            im_wr_en     <= 1'b1;
            im_wr_addr   <= addr;
            im_wr_data   <= in_data;
            words_loaded <= words_loaded + 1'b1;
            addr         <= addr + 1'b1;
            if (in_last) begin
              in_ready <= 1'b0;
              start    <= 1'b1;
              st_cnt   <= '0;
              state    <= START;
            end else if (addr == AW'(IM_SIZE - 1)) begin
              in_ready <= 1'b0;
              err_q    <= ERR_OVERFLOW;
              state    <= ERROR;
            end
          end
        end
        START: begin
          if (st_cnt == SCW'(START_CYCLES - 1)) begin
            start <= 1'b0;
            state <= RUN;
          end else begin
            st_cnt <= st_cnt + 1'b1;
          end
        end
        RUN: begin
          if (done) begin
            run_done <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (timeout_hit) begin
            err_q <= ERR_TIMEOUT;
            state <= ERROR;
          end
        end
        ERROR: begin
          state <= ERROR;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench: default-size loader for load/run/reset cases, small loader for overflow/timeout.
module tb_prog_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic        a_reset, a_load_req, a_in_valid, a_in_last, a_done;
  logic [8:0]  a_in_data;
  logic        a_in_ready, a_wr_en, a_start, a_busy, a_run_done;
  logic [9:0]  a_wr_addr;
  logic [8:0]  a_wr_data;
  logic [1:0]  a_err;
  logic [15:0] a_run_cycles;
  logic [10:0] a_words;

  // Instance B: 8-word memory, 20-cycle timeout
  logic        b_reset, b_load_req, b_in_valid, b_in_last, b_done;
  logic [8:0]  b_in_data;
  logic        b_in_ready, b_wr_en, b_start, b_busy, b_run_done;
  logic [2:0]  b_wr_addr;
  logic [8:0]  b_wr_data;
  logic [1:0]  b_err;
  logic [15:0] b_run_cycles;
  logic [3:0]  b_words;

  prog_loader u_a (
    .clk(clk), .reset(a_reset), .load_req(a_load_req), .in_valid(a_in_valid),
    .in_data(a_in_data), .in_last(a_in_last), .in_ready(a_in_ready),
    .im_wr_en(a_wr_en), .im_wr_addr(a_wr_addr), .im_wr_data(a_wr_data),
    .start(a_start), .done(a_done), .busy(a_busy), .run_done(a_run_done),
    .err_code(a_err), .run_cycles(a_run_cycles), .words_loaded(a_words)
  );

  prog_loader #(.IM_SIZE(8), .AW(3), .TIMEOUT(20)) u_b (
    .clk(clk), .reset(b_reset), .load_req(b_load_req), .in_valid(b_in_valid),
    .in_data(b_in_data), .in_last(b_in_last), .in_ready(b_in_ready),
    .im_wr_en(b_wr_en), .im_wr_addr(b_wr_addr), .im_wr_data(b_wr_data),
    .start(b_start), .done(b_done), .busy(b_busy), .run_done(b_run_done),
    .err_code(b_err), .run_cycles(b_run_cycles), .words_loaded(b_words)
  );

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t qa[$];
  wr_t qb[$];
  int  n_vec = 0;
  int  n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Write monitors: every im_wr_en pulse must match the oldest expected write
  always @(negedge clk) begin
    wr_t e;
    if (a_wr_en === 1'b1) begin
      if (qa.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL a_unexpected_write: addr %0d data 0x%0h, none expected", a_wr_addr, a_wr_data);
      end else begin
        e = qa.pop_front();
        chk("a_wr_addr", int'(a_wr_addr), e.addr);
        chk("a_wr_data", int'(a_wr_data), e.data);
      end
    end
    if (b_wr_en === 1'b1) begin
      if (qb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL b_unexpected_write: addr %0d data 0x%0h, none expected", b_wr_addr, b_wr_data);
      end else begin
        e = qb.pop_front();
        chk("b_wr_addr", int'(b_wr_addr), e.addr);
        chk("b_wr_data", int'(b_wr_data), e.data);
      end
    end
  end

  function automatic wr_t mk(input int addr, input int data);
    wr_t w;
    w.addr = addr;
    w.data = data;
    return w;
  endfunction

  task automatic a_drive(input logic v, input logic [8:0] d, input logic l);
    a_in_valid = v;
    a_in_data  = d;
    a_in_last  = l;
    @(negedge clk);
  endtask

  task automatic b_drive(input logic v, input logic [8:0] d, input logic l);
    b_in_valid = v;
    b_in_data  = d;
    b_in_last  = l;
    @(negedge clk);
  endtask

  // From the negedge after the last transfer: ride out START, run n cycles, then raise done
  task automatic a_finish_run(input int n);
    a_in_valid = 1'b0;
    a_in_last  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("a_start_released", int'(a_start), 0);
    repeat (n) @(posedge clk);
    @(negedge clk);
    a_done = 1'b1;
    @(negedge clk);
    a_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_reset = 1'b1; a_load_req = 1'b0; a_in_valid = 1'b0; a_in_last = 1'b0; a_done = 1'b0; a_in_data = '0;
    b_reset = 1'b1; b_load_req = 1'b0; b_in_valid = 1'b0; b_in_last = 1'b0; b_done = 1'b0; b_in_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(a_in_ready), 0);
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_start", int'(a_start), 0);
    chk("rst_wr_en", int'(a_wr_en), 0);
    chk("rst_err", int'(a_err), 0);
    chk("rst_run_cycles", int'(a_run_cycles), 0);
    chk("rst_words", int'(a_words), 0);
    chk("rst_b_busy", int'(b_busy), 0);
    a_reset = 1'b0;
    b_reset = 1'b0;
    @(negedge clk);

    // 4-word program, valid held high, done pulse during START, run of 37 cycles
    a_load_req = 1'b1;
    @(negedge clk);
    a_load_req = 1'b0;
    chk("t1_in_ready", int'(a_in_ready), 1);
    chk("t1_busy", int'(a_busy), 1);
    qa.push_back(mk(0, 'h1A3));
    qa.push_back(mk(1, 'h000));
    qa.push_back(mk(2, 'h1FF));
    qa.push_back(mk(3, 'h055));
    a_drive(1'b1, 9'h1A3, 1'b0);
    a_drive(1'b1, 9'h000, 1'b0);
    a_drive(1'b1, 9'h1FF, 1'b0);
    a_drive(1'b1, 9'h055, 1'b1);
    a_in_valid = 1'b0;
    a_in_last  = 1'b0;
    chk("t1_words", int'(a_words), 4);
    chk("t1_start_c1", int'(a_start), 1);
    chk("t1_in_ready_off", int'(a_in_ready), 0);
    a_done = 1'b1;
    @(negedge clk);
    a_done = 1'b0;
    chk("t1_start_c2", int'(a_start), 1);
    @(negedge clk);
    chk("t1_start_c3", int'(a_start), 0);
    chk("t1_done_in_start_ignored", int'(a_run_done), 0);
    chk("t1_still_busy", int'(a_busy), 1);
    repeat (37) @(posedge clk);
    @(negedge clk);
    a_done = 1'b1;
    @(negedge clk);
    a_done = 1'b0;
    chk("t1_run_done", int'(a_run_done), 1);
    chk("t1_run_cycles", int'(a_run_cycles), 37);
    chk("t1_busy_end", int'(a_busy), 0);
    chk("t1_err", int'(a_err), 0);
    chk("t1_queue_empty", qa.size(), 0);

    // 3 words with in_valid toggling; idle cycles carry junk data that must not be written
    a_load_req = 1'b1;
    @(negedge clk);
    a_load_req = 1'b0;
    chk("t2_run_done_cleared", int'(a_run_done), 0);
    chk("t2_run_cycles_cleared", int'(a_run_cycles), 0);
    chk("t2_words_cleared", int'(a_words), 0);
    qa.push_back(mk(0, 'h0AA));
    qa.push_back(mk(1, 'h155));
    qa.push_back(mk(2, 'h001));
    a_drive(1'b1, 9'h0AA, 1'b0);
    a_drive(1'b0, 9'h1EE, 1'b1);
    a_drive(1'b1, 9'h155, 1'b0);
    a_drive(1'b0, 9'h033, 1'b1);
    a_drive(1'b1, 9'h001, 1'b1);
    chk("t2_words", int'(a_words), 3);
    a_finish_run(4);
    chk("t2_run_cycles", int'(a_run_cycles), 4);
    chk("t2_run_done", int'(a_run_done), 1);
    chk("t2_queue_empty", qa.size(), 0);

    // Reset on the edge of the 3rd transfer of a 5-word load
    a_load_req = 1'b1;
    @(negedge clk);
    a_load_req = 1'b0;
    qa.push_back(mk(0, 'h101));
    qa.push_back(mk(1, 'h102));
    a_drive(1'b1, 9'h101, 1'b0);
    a_drive(1'b1, 9'h102, 1'b0);
    a_reset = 1'b1;
    a_drive(1'b1, 9'h103, 1'b0);
    a_reset    = 1'b0;
    a_in_valid = 1'b0;
    chk("t3_wr_en_dropped", int'(a_wr_en), 0);
    chk("t3_busy_idle", int'(a_busy), 0);
    chk("t3_in_ready_idle", int'(a_in_ready), 0);
    chk("t3_words_reset", int'(a_words), 0);
    a_load_req = 1'b1;
    @(negedge clk);
    a_load_req = 1'b0;
    qa.push_back(mk(0, 'h120));
    qa.push_back(mk(1, 'h121));
    a_drive(1'b1, 9'h120, 1'b0);
    a_drive(1'b1, 9'h121, 1'b1);
    chk("t3_words", int'(a_words), 2);
    a_finish_run(5);
    chk("t3_run_cycles", int'(a_run_cycles), 5);
    chk("t3_queue_empty", qa.size(), 0);

    // Overflow on the 8-word instance: 9 words offered, none marked last
    b_load_req = 1'b1;
    @(negedge clk);
    b_load_req = 1'b0;
    for (int i = 0; i < 8; i++) qb.push_back(mk(i, 'h10 + i));
    for (int i = 0; i < 8; i++) b_drive(1'b1, 9'(16 + i), 1'b0);
    chk("t4_in_ready_off", int'(b_in_ready), 0);
    chk("t4_err_overflow", int'(b_err), 1);
    chk("t4_busy", int'(b_busy), 1);
    chk("t4_words", int'(b_words), 8);
    b_in_data  = 9'h1F0;
    b_load_req = 1'b1;
    @(negedge clk);
    b_load_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_err_held", int'(b_err), 1);
    chk("t4_busy_held", int'(b_busy), 1);
    chk("t4_start_off", int'(b_start), 0);
    chk("t4_queue_empty", qb.size(), 0);
    b_in_valid = 1'b0;
    b_reset    = 1'b1;
    @(negedge clk);
    b_reset = 1'b0;
    chk("t4_err_cleared", int'(b_err), 0);
    chk("t4_busy_cleared", int'(b_busy), 0);

    // Timeout on the small instance with done held low; single-word program
    b_load_req = 1'b1;
    @(negedge clk);
    b_load_req = 1'b0;
    qb.push_back(mk(0, 'h0F0));
    b_drive(1'b1, 9'h0F0, 1'b1);
    b_in_valid = 1'b0;
    b_in_last  = 1'b0;
    chk("t5_words_single", int'(b_words), 1);
    for (int k = 0; k < 100 && b_err == 2'd0; k++) @(negedge clk);
    chk("t5_err_timeout", int'(b_err), 2);
    chk("t5_run_cycles", int'(b_run_cycles), 20);
    chk("t5_start_off", int'(b_start), 0);
    chk("t5_busy", int'(b_busy), 1);
    repeat (3) @(negedge clk);
    chk("t5_err_held", int'(b_err), 2);
    chk("t5_run_done_clear", int'(b_run_done), 0);
    chk("t5_queue_empty", qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
